// File: rtl/msg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | msg_pkg : message geometry, field slicing and TX state encoding     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package msg_pkg;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_LOAD = 2'd1,
      TX_SEND = 2'd2,
      TX_WAIT = 2'd3
   } tx_state_t;

   function automatic int MSG_WIDTH(input int aw);
      return 2 * (aw + 1) + 4;
   endfunction

   // Fields come back zero-extended to a full UART byte.
   function automatic logic [7:0] msg_i(input logic [31:0] m, input int aw);
      logic [31:0] mask;
      mask = (32'd1 << (aw + 1)) - 32'd1;
      return 8'((m >> (aw + 5)) & mask);
   endfunction

   function automatic logic [7:0] msg_j(input logic [31:0] m, input int aw);
      logic [31:0] mask;
      mask = (32'd1 << (aw + 1)) - 32'd1;
      return 8'((m >> 4) & mask);
   endfunction

   function automatic logic [7:0] msg_status(input logic [31:0] m);
      return 8'(m & 32'h0000_000F);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : first-word fall-through FIFO, async active-high reset   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Push is gated on the pre-edge full flag, so a same-cycle pop never makes room.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign dout  = mem_q[rd_ptr_q[PW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= din;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_msg_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_msg_bridge : UART byte stream <-> cell message bridge          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uart_msg_bridge
   import msg_pkg::*;
#(
   parameter int N          = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 4,
   parameter int TIMEOUT    = 1000000,
   localparam int MW        = MSG_WIDTH(ADDR_WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rxdata,
   input  logic          rxfinish,
   output logic [7:0]    txdata,
   output logic          send,
   input  logic          txdone,
   output logic [MW-1:0] rxmessage,
   output logic          rxvalid,
   input  logic          ack_rxmessage,
   input  logic [MW-1:0] txmessage,
   input  logic          txvalid,
   output logic          ack_txmessage,
   output logic          frame_error,
   output logic [7:0]    drop_count
);
   localparam int            FW     = ADDR_WIDTH + 1;
   localparam int            TW     = $clog2(TIMEOUT + 1);
   localparam logic [FW:0]   N_LIM  = N[FW:0];
   localparam logic [TW-1:0] TO_LIM = TIMEOUT[TW-1:0];

   // ---------------- RX assembler ----------------
   logic [1:0]    idx_q, idx_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] i_q, i_d, j_q, j_d;
   logic          ferr_q, ferr_d;
   logic [7:0]    drop_q, drop_d;
   logic          frame_done, in_range, rx_push, rx_full, rx_empty;
   logic [MW-1:0] rx_din, rx_dout;
   logic          unused_rx_bits;

   assign unused_rx_bits = ^rxdata[7:FW];
   assign in_range = ({1'b0, i_q} < N_LIM) && ({1'b0, j_q} < N_LIM);
   assign rx_din   = {i_q, j_q, rxdata[3:0]};

   always_comb begin
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      i_d        = i_q;
      j_d        = j_q;
      ferr_d     = 1'b0;
      drop_d     = drop_q;
      frame_done = 1'b0;
      if (rxfinish) begin
         cnt_d = '0;
         case (idx_q)
            2'd0: begin
               i_d   = rxdata[FW-1:0];
               idx_d = 2'd1;
            end
            2'd1: begin
               j_d   = rxdata[FW-1:0];
               idx_d = 2'd2;
            end
            default: begin
               idx_d      = 2'd0;
               frame_done = 1'b1;
            end
         endcase
      end else if (idx_q != 2'd0) begin
         if (cnt_q + TW'(1) == TO_LIM) begin
            idx_d  = 2'd0;
            cnt_d  = '0;
            ferr_d = 1'b1;
         end else begin
            cnt_d = cnt_q + TW'(1);
         end
      end
      rx_push = frame_done && in_range && !rx_full;
      if (frame_done && !rx_push && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= 2'd0;
         cnt_q  <= '0;
         i_q    <= '0;
         j_q    <= '0;
         ferr_q <= 1'b0;
         drop_q <= 8'd0;
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         i_q    <= i_d;
         j_q    <= j_d;
         ferr_q <= ferr_d;
         drop_q <= drop_d;
      end
   end

   sync_fifo #(.WIDTH(MW), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (ack_rxmessage),
      .din   (rx_din),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign rxvalid     = !rx_empty;
   assign rxmessage   = rx_empty ? '0 : rx_dout;
   assign frame_error = ferr_q;
   assign drop_count  = drop_q;

   // ---------------- TX accept ----------------
   logic          ack_q, ack_d;
   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic [MW-1:0] tx_dout;

   // The cycle after an ack is blind to txvalid so a held request is not re-pushed.
   always_comb begin
      tx_push = txvalid && !tx_full && !ack_q;
      ack_d   = tx_push;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ack_q <= 1'b0;
      else     ack_q <= ack_d;
   end

   assign ack_txmessage = ack_q;

   sync_fifo #(.WIDTH(MW), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (txmessage),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty)
   );

   // ---------------- TX serialiser ----------------
   tx_state_t     state_q;
   logic [1:0]    tidx_q;
   logic [MW-1:0] msg_q;
   logic [7:0]    txdata_q, cur_byte;
   logic          send_q;

   assign tx_pop = (state_q == TX_IDLE) && !tx_empty;

   always_comb begin
      case (tidx_q)
         2'd0:    cur_byte = msg_i(32'(msg_q), ADDR_WIDTH);
         2'd1:    cur_byte = msg_j(32'(msg_q), ADDR_WIDTH);
         default: cur_byte = msg_status(32'(msg_q));
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= TX_IDLE;
         tidx_q   <= 2'd0;
         msg_q    <= '0;
         txdata_q <= 8'd0;
         send_q   <= 1'b0;
      end else begin
         send_q <= 1'b0;
         case (state_q)
            TX_IDLE: begin
               if (!tx_empty) begin
                  msg_q   <= tx_dout;
                  tidx_q  <= 2'd0;
                  state_q <= TX_LOAD;
               end
            end
            TX_LOAD: begin
               txdata_q <= cur_byte;
               send_q   <= 1'b1;
               state_q  <= TX_SEND;
            end
            TX_SEND: state_q <= TX_WAIT;
            TX_WAIT: begin
               if (txdone) begin
                  if (tidx_q == 2'd2) begin
                     state_q <= TX_IDLE;
                  end else begin
                     tidx_q  <= tidx_q + 2'd1;
                     state_q <= TX_LOAD;
                  end
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign txdata = txdata_q;
   assign send   = send_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_msg_bridge : randomized bench with queue-based reference    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_uart_msg_bridge;
   localparam int N       = 16;
   localparam int AW      = 4;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 20;
   localparam int MW      = 2 * (AW + 1) + 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rxdata;
   logic          rxfinish;
   logic [7:0]    txdata;
   logic          send;
   logic          txdone;
   logic [MW-1:0] rxmessage;
   logic          rxvalid;
   logic          ack_rxmessage;
   logic [MW-1:0] txmessage;
   logic          txvalid;
   logic          ack_txmessage;
   logic          frame_error;
   logic [7:0]    drop_count;

   uart_msg_bridge #(.N(N), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .rxdata(rxdata), .rxfinish(rxfinish),
      .txdata(txdata), .send(send), .txdone(txdone),
      .rxmessage(rxmessage), .rxvalid(rxvalid), .ack_rxmessage(ack_rxmessage),
      .txmessage(txmessage), .txvalid(txvalid), .ack_txmessage(ack_txmessage),
      .frame_error(frame_error), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]    m_bytes[$];
   logic [MW-1:0] m_rxq[$];
   logic [7:0]    m_txq[$];
   int m_idle, m_drop, m_occ, m_done;
   bit m_ferr, m_ack, m_busy, m_wait, m_pend, m_send;
   int mi, mj, mst;
   bit full_rx, push_tx, pop_tx, adv;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_bytes.delete(); m_rxq.delete(); m_txq.delete();
         m_idle = 0; m_drop = 0; m_occ = 0; m_done = 0;
         m_ferr = 0; m_ack = 0; m_busy = 0; m_wait = 0; m_pend = 0; m_send = 0;
      end else begin
         // receive side: frames of three bytes, checked and queued
         full_rx = (m_rxq.size() == DEPTH);
         if (ack_rxmessage && m_rxq.size() > 0) void'(m_rxq.pop_front());
         m_ferr = 0;
         if (rxfinish) begin
            m_bytes.push_back(rxdata);
            m_idle = 0;
            if (m_bytes.size() == 3) begin
               mi  = int'(m_bytes[0]) % 32;
               mj  = int'(m_bytes[1]) % 32;
               mst = int'(m_bytes[2]) % 16;
               if (mi >= N || mj >= N || full_rx) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
               else m_rxq.push_back(MW'(mi * 512 + mj * 16 + mst));
               m_bytes.delete();
            end
         end else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_bytes.delete();
               m_idle = 0;
               m_ferr = 1;
            end
         end
         // transmit side: occupancy, one frame in flight, 3 bytes each
         push_tx = txvalid && (m_occ < DEPTH) && !m_ack;
         pop_tx  = !m_busy && (m_occ > 0);
         adv = 0;
         if (txdone && m_wait) begin
            m_wait = 0;
            m_done++;
            if (m_done == 3) m_busy = 0;
            else adv = 1;
         end
         if (m_send) m_wait = 1;
         m_send = m_pend;
         m_pend = adv;
         if (pop_tx) begin
            m_busy = 1;
            m_done = 0;
            m_pend = 1;
         end
         if (push_tx) begin
            m_txq.push_back(8'(int'(txmessage) / 512));
            m_txq.push_back(8'((int'(txmessage) / 16) % 32));
            m_txq.push_back(8'(int'(txmessage) % 16));
         end
         m_occ = m_occ + int'(push_tx) - int'(pop_tx);
         m_ack = push_tx;
      end
   end

   // ---------------- compare ----------------
   int n_sends = 0;
   int n_ferr  = 0;
   logic [7:0] sent_log[$];

   initial forever begin
      @(negedge clk);
      check("rxvalid", 32'(rxvalid), 32'(m_rxq.size() > 0));
      check("rxmessage", 32'(rxmessage), 32'(m_rxq.size() > 0 ? m_rxq[0] : '0));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      check("frame_error", 32'(frame_error), 32'(m_ferr));
      check("ack_txmessage", 32'(ack_txmessage), 32'(m_ack));
      check("send", 32'(send), 32'(m_send));
      if (send) begin
         n_sends++;
         sent_log.push_back(txdata);
      end
      if (frame_error) n_ferr++;
      if (m_send) begin
         n_cmp++;
         if (m_txq.size() == 0) begin
            n_bad++;
            $display("FAIL txdata: got 0x%0h, expected no byte pending", txdata);
         end else if (txdata !== m_txq[0]) begin
            n_bad++;
            $display("FAIL txdata: got 0x%0h, expected 0x%0h", txdata, m_txq[0]);
            void'(m_txq.pop_front());
         end else begin
            void'(m_txq.pop_front());
         end
      end
   end

   // ---------------- UART transmitter stand-in ----------------
   int rst_gen = 0;
   initial forever begin
      @(negedge clk);
      if (send && !rst) begin
         int gen;
         int k;
         gen = rst_gen;
         k = $urandom_range(1, 3);
         repeat (k) @(posedge clk);
         #3;
         if (gen == rst_gen && !rst) begin
            txdone = 1'b1;
            @(posedge clk);
            #3;
            txdone = 1'b0;
         end
      end
   end

   // ---------------- random cell sources / sinks ----------------
   bit rx_auto = 0;
   bit tx_auto = 0;
   initial forever begin
      @(posedge clk);
      #2;
      if (rx_auto) ack_rxmessage = ($urandom_range(0, 2) == 0);
      if (tx_auto && (ack_txmessage || !txvalid)) begin
         txvalid   = ($urandom_range(0, 3) == 0);
         txmessage = MW'($urandom);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic put_byte(input logic [7:0] b);
      rxdata   = b;
      rxfinish = 1'b1;
      tick();
      rxfinish = 1'b0;
   endtask

   task automatic put_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      put_byte(a);
      put_byte(b);
      put_byte(c);
   endtask

   task automatic pop_rx();
      ack_rxmessage = 1'b1;
      tick();
      ack_rxmessage = 1'b0;
   endtask

   task automatic wait_sends(input int target, input int budget);
      for (int c = 0; c < budget && n_sends < target; c++) tick();
      check("send_count", 32'(n_sends), 32'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   int base;
   logic [7:0] b;
   logic [MW-1:0] exp_msg;

   initial begin
      rst = 1'b1; rxdata = 8'd0; rxfinish = 1'b0; txdone = 1'b0;
      ack_rxmessage = 1'b0; txmessage = '0; txvalid = 1'b0;
      repeat (3) tick();
      check("rst_rxvalid", 32'(rxvalid), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      check("rst_send", 32'(send), 32'd0);
      check("rst_txdata", 32'(txdata), 32'd0);
      rst = 1'b0;
      tick();

      // basic frame and pop
      put_frame(8'h03, 8'h05, 8'h09);
      check("basic_valid", 32'(rxvalid), 32'd1);
      check("basic_msg", 32'(rxmessage), 32'h0659);
      pop_rx();
      check("basic_popped", 32'(rxvalid), 32'd0);

      // range check, upper bits ignored on the in-range frame
      put_frame(8'h10, 8'h02, 8'h01);
      check("range_drop", 32'(drop_count), 32'd1);
      check("range_novalid", 32'(rxvalid), 32'd0);
      put_frame(8'h0F, 8'hEF, 8'hFF);
      check("range_edge_msg", 32'(rxmessage), 32'h1EFF);
      pop_rx();

      // overflow: fifth frame lost, first four returned in order
      for (int k = 1; k <= 5; k++) put_frame(8'(k), 8'(k + 1), 8'(k + 2));
      check("ovf_drop", 32'(drop_count), 32'd2);
      for (int k = 1; k <= 4; k++) begin
         exp_msg = MW'(k * 512 + (k + 1) * 16 + (k + 2));
         check("ovf_order", 32'(rxmessage), 32'(exp_msg));
         pop_rx();
      end
      check("ovf_empty", 32'(rxvalid), 32'd0);

      // partial-frame timeout
      put_byte(8'h01);
      put_byte(8'h02);
      base = n_ferr;
      repeat (19) tick();
      check("to_early", 32'(n_ferr), 32'(base));
      tick();
      check("to_pulse", 32'(frame_error), 32'd1);
      tick();
      check("to_single", 32'(frame_error), 32'd0);
      put_frame(8'h04, 8'h06, 8'h02);
      check("to_resync_msg", 32'(rxmessage), 32'h0862);
      check("to_no_drop", 32'(drop_count), 32'd2);
      pop_rx();

      // TX serialisation
      sent_log.delete();
      base = n_sends;
      txmessage = 14'h0659;
      txvalid = 1'b1;
      tick();
      check("tx_ack", 32'(ack_txmessage), 32'd1);
      txvalid = 1'b0;
      tick();
      check("tx_ack_once", 32'(ack_txmessage), 32'd0);
      wait_sends(base + 3, 100);
      check("tx_b0", 32'(sent_log[0]), 32'h03);
      check("tx_b1", 32'(sent_log[1]), 32'h05);
      check("tx_b2", 32'(sent_log[2]), 32'h09);
      repeat (8) tick();

      // reset while waiting on the second byte
      base = n_sends;
      txmessage = 14'h1234;
      txvalid = 1'b1;
      tick();
      txvalid = 1'b0;
      wait_sends(base + 2, 100);
      rst = 1'b1;
      rst_gen++;
      #1;
      check("mid_rst_send", 32'(send), 32'd0);
      check("mid_rst_txdata", 32'(txdata), 32'd0);
      check("mid_rst_ack", 32'(ack_txmessage), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      base = n_sends;
      txdone = 1'b1;
      tick();
      txdone = 1'b0;
      repeat (10) tick();
      check("post_rst_nosend", 32'(n_sends), 32'(base));

      // randomized traffic on both paths
      rx_auto = 1;
      tx_auto = 1;
      for (int f = 0; f < 700; f++) begin
         if ($urandom_range(0, 49) == 0) repeat (TIMEOUT + 3) tick();
         else repeat ($urandom_range(0, 2)) tick();
         b = 8'($urandom_range(0, 7) * 32 + $urandom_range(0, 17));
         put_byte(b);
      end
      rx_auto = 0;
      tx_auto = 0;
      txvalid = 1'b0;
      ack_rxmessage = 1'b1;
      for (int c = 0; c < 3000 && (m_rxq.size() > 0 || m_occ > 0 || m_busy); c++) tick();
      ack_rxmessage = 1'b0;
      check("drain_rx_empty", 32'(rxvalid), 32'd0);
      n_cmp++;
      if (m_occ > 0 || m_busy) begin
         n_bad++;
         $display("FAIL drain_tx: got occ=%0d busy=%0d, expected idle", m_occ, m_busy);
      end
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
